arb_mux: RTL and testbench

ARB_MUX -- requirements
Module: arb_mux

---
 rtl/arb_mux.sv | 116 +++++++++++
 tb/tb_arb_mux.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/arb_mux.sv
// Arbitrated N-to-1 multiplexer with a single-entry registered output stage.
// Round-robin or fixed-priority grant; the output refills in the same cycle it drains.
module arb_mux #(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  parameter int RR    = 1,
  localparam int SW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SW-1:0]      out_sel,
  input  logic               out_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_r;
  logic [WIDTH-1:0] data_r;
  logic [SW-1:0]    sel_r;
  logic [SW-1:0]    ptr_r;

  logic             grant_any_s;
  logic [SW-1:0]    grant_idx_s;
  logic [N-1:0]     grant_vec_s;
  logic [WIDTH-1:0] grant_data_s;
  logic [SW-1:0]    ptr_next_s;
  logic             can_accept_s;
  logic             xfer_s;

  // Grant: the requester with the smallest circular distance from ptr wins.
  always_comb begin
    int best_v;
    int dist_v;
    int p_v;
    best_v       = N;
    dist_v       = 0;
    p_v          = int'(ptr_r);
    grant_any_s  = 1'b0;
    grant_idx_s  = '0;
    grant_data_s = '0;
    grant_vec_s  = '0;
    for (int i = 0; i < N; i++) begin
      if (i >= p_v) begin
        dist_v = i - p_v;
      end else begin
        dist_v = i + N - p_v;
      end
      if (in_valid[i] && (dist_v < best_v)) begin
        best_v       = dist_v;
        grant_any_s  = 1'b1;
        grant_idx_s  = SW'(i);
        grant_data_s = in_data[i*WIDTH +: WIDTH];
      end else begin
        best_v = best_v;
      end
    end
    for (int i = 0; i < N; i++) begin
      grant_vec_s[i] = grant_any_s && (grant_idx_s == SW'(i));
    end
  end

  // Pointer advances past the winner in round-robin mode, stays at 0 otherwise.
  always_comb begin
    if ((RR == 0) || (grant_idx_s == SW'(N - 1))) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = grant_idx_s + SW'(1);
    end
  end

  assign can_accept_s = (state_r == EMPTY) || out_ready;
  assign xfer_s       = grant_any_s && can_accept_s && !rst;
  assign in_ready     = xfer_s ? grant_vec_s : '0;

  // Output register FSM and priority pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= EMPTY;
      data_r  <= '0;
      sel_r   <= '0;
      ptr_r   <= '0;
    end else begin
      case (state_r)
        EMPTY: begin
          if (xfer_s) begin
            state_r <= FULL;
            data_r  <= grant_data_s;
            sel_r   <= grant_idx_s;
          end
        end
        FULL: begin
          if (xfer_s) begin
            data_r <= grant_data_s;
            sel_r  <= grant_idx_s;
          end else if (out_ready) begin
            state_r <= EMPTY;
          end
        end
        default: state_r <= EMPTY;
      endcase
      if (xfer_s) begin
        ptr_r <= ptr_next_s;
      end
    end
  end

  assign out_valid = (state_r == FULL);
  assign out_data  = data_r;
  assign out_sel   = sel_r;

endmodule

// File: tb/tb_arb_mux.sv
// Self-checking bench for arb_mux: round-robin N=4, fixed-priority N=4 and N=1/WIDTH=8
// instances run side by side against a behavioural model of the grant and output rules.
module tb_arb_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  iv   [3];
  logic [63:0] id   [3];
  logic        ordy [3];

  logic [3:0]  rdy_a, rdy_b;
  logic        val_a, val_b, val_c, rdy_c;
  logic [15:0] dat_a, dat_b;
  logic [7:0]  dat_c;
  logic [1:0]  sel_a, sel_b;
  logic        sel_c;

  logic [3:0]  o_rdy [3];
  logic        o_val [3];
  logic [15:0] o_dat [3];
  logic [1:0]  o_sel [3];

  logic        m_valid [3];
  logic [15:0] m_data  [3];
  int          m_sel   [3];
  int          m_ptr   [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  arb_mux #(.WIDTH(16), .N(4), .RR(1)) u_rr (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_data(id[0]), .in_ready(rdy_a),
    .out_valid(val_a), .out_data(dat_a), .out_sel(sel_a), .out_ready(ordy[0]));

  arb_mux #(.WIDTH(16), .N(4), .RR(0)) u_fp (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_data(id[1]), .in_ready(rdy_b),
    .out_valid(val_b), .out_data(dat_b), .out_sel(sel_b), .out_ready(ordy[1]));

  arb_mux #(.WIDTH(8), .N(1), .RR(1)) u_n1 (
    .clk(clk), .rst(rst), .in_valid(iv[2][0]), .in_data(id[2][7:0]), .in_ready(rdy_c),
    .out_valid(val_c), .out_data(dat_c), .out_sel(sel_c), .out_ready(ordy[2]));

  assign o_rdy[0] = rdy_a;
  assign o_rdy[1] = rdy_b;
  assign o_rdy[2] = {3'b000, rdy_c};
  assign o_val[0] = val_a;
  assign o_val[1] = val_b;
  assign o_val[2] = val_c;
  assign o_dat[0] = dat_a;
  assign o_dat[1] = dat_b;
  assign o_dat[2] = {8'h00, dat_c};
  assign o_sel[0] = sel_a;
  assign o_sel[1] = sel_b;
  assign o_sel[2] = {1'b0, sel_c};

  function automatic int n_of(int i);
    return (i == 2) ? 1 : 4;
  endfunction

  function automatic bit rr_of(int i);
    return (i != 1);
  endfunction

  // Scan ptr, ptr+1, ... (mod n) for the first requester; -1 if none.
  function automatic int mgrant(int i);
    for (int k = 0; k < n_of(i); k++) begin
      int ch = (m_ptr[i] + k) % n_of(i);
      if (iv[i][ch]) return ch;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_rdy(int i);
    int g = mgrant(i);
    if (rst || g < 0 || (m_valid[i] && !ordy[i])) return 4'b0000;
    return 4'(1 << g);
  endfunction

  task automatic mreset();
    for (int i = 0; i < 3; i++) begin
      m_valid[i] = 1'b0;
      m_data[i]  = 16'h0000;
      m_sel[i]   = 0;
      m_ptr[i]   = 0;
    end
  endtask

  task automatic mupdate();
    if (rst) begin
      mreset();
    end else begin
      for (int i = 0; i < 3; i++) begin
        int g = mgrant(i);
        if ((!m_valid[i] || ordy[i]) && g >= 0) begin
          m_valid[i] = 1'b1;
          m_data[i]  = id[i][g*16 +: 16];
          m_sel[i]   = g;
          if (rr_of(i)) m_ptr[i] = (g + 1) % n_of(i);
        end else if (m_valid[i] && ordy[i]) begin
          m_valid[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rdy();
    for (int i = 0; i < 3; i++)
      chk($sformatf("in_ready[%0d]", i), {28'b0, o_rdy[i]}, {28'b0, exp_rdy(i)});
  endtask

  task automatic check_out();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("out_valid[%0d]", i), {31'b0, o_val[i]}, {31'b0, m_valid[i]});
      chk($sformatf("out_data[%0d]", i), {16'b0, o_dat[i]}, {16'b0, m_data[i]});
      chk($sformatf("out_sel[%0d]", i), {30'b0, o_sel[i]}, 32'(m_sel[i]));
    end
  endtask

  // Inputs are set at the falling edge; readies are checked before, outputs after, the rising edge.
  task automatic step();
    #1;
    check_rdy();
    @(posedge clk);
    mupdate();
    #1;
    check_out();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    mreset();
    iv[0] = 4'hF; iv[1] = 4'hF; iv[2] = 4'h1;
    for (int i = 0; i < 3; i++) begin
      id[i]   = 64'h0;
      ordy[i] = 1'b1;
    end

    @(negedge clk);
    check_rdy();
    check_out();
    chk("rst_rdy_a", {28'b0, rdy_a}, 32'h0);
    rst = 1'b0;

    // Round-robin rotation and fixed-priority starvation of channel 3.
    id[0] = {16'd3, 16'd2, 16'd1, 16'd0};
    iv[1] = 4'b1010;
    id[1] = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
    id[2] = 64'h5A;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("rr_seq", {30'b0, sel_a}, 32'(k % 4));
      chk("rr_data", {16'b0, dat_a}, 32'(k % 4));
      chk("rr_valid", {31'b0, val_a}, 32'h1);
      chk("fp_sel", {30'b0, sel_b}, 32'h1);
      chk("fp_data", {16'b0, dat_b}, 32'h1111);
    end

    // Backpressure hold, then same-cycle refill from the next grantee.
    id[0][15:0] = 16'hBEEF;
    iv[0] = 4'b0001;
    step();
    chk("bp_load", {16'b0, dat_a}, 32'hBEEF);
    ordy[0] = 1'b0;
    iv[0] = 4'hF;
    id[0][15:0] = 16'h1234;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_data", {16'b0, dat_a}, 32'hBEEF);
      chk("bp_valid", {31'b0, val_a}, 32'h1);
      chk("bp_sel", {30'b0, sel_a}, 32'h0);
      chk("bp_rdy", {28'b0, rdy_a}, 32'h0);
    end
    ordy[0] = 1'b1;
    #1;
    chk("bp_refill_rdy", {28'b0, rdy_a}, 32'h2);
    step();
    chk("bp_refill_sel", {30'b0, sel_a}, 32'h1);
    chk("bp_refill_data", {16'b0, dat_a}, 32'h1);

    // Pointer wrap from 3 back through 0.
    iv[0] = 4'b0100;
    step();
    chk("wrap_pre", {30'b0, sel_a}, 32'h2);
    iv[0] = 4'b0001;
    step();
    chk("wrap_sel", {30'b0, sel_a}, 32'h0);
    iv[0] = 4'hF;
    step();
    chk("wrap_ptr", {30'b0, sel_a}, 32'h1);

    // Asynchronous reset between edges while full.
    #2;
    rst = 1'b1;
    #1;
    mreset();
    chk("arst_valid", {31'b0, val_a}, 32'h0);
    chk("arst_data", {16'b0, dat_a}, 32'h0);
    chk("arst_sel", {30'b0, sel_a}, 32'h0);
    chk("arst_rdy", {28'b0, rdy_a}, 32'h0);
    check_out();
    @(negedge clk);
    rst = 1'b0;
    iv[0] = 4'hF;
    #1;
    chk("post_rst_rdy", {28'b0, rdy_a}, 32'h1);
    step();
    chk("post_rst_sel", {30'b0, sel_a}, 32'h0);

    // Random traffic; the single-channel instance alternates its request.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        iv[i]   = 4'($urandom);
        id[i]   = {$urandom, $urandom};
        ordy[i] = ($urandom_range(0, 3) != 0);
      end
      iv[2]   = {3'b000, c[0]};
      id[2]   = {56'h0, 8'($urandom)};
      ordy[2] = 1'($urandom);
      step();
      chk("n1_sel", {31'b0, sel_c}, 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
